serial_word_collector: RTL and testbench
========================================

// Module: serial_word_collector
// PURPOSE
//   Downstream stage of the parallel-load shift register: consumes its serial
//   output SO (LSB-first, one bit per strobe) and reassembles n-bit words.
//   Each completed word goes into a one-entry holding register.
//   The holding register is drained by a valid/ready handshake.
//   Detects and flags overrun when the consumer stalls.
// PARAMETERS
//   n   4   word width in bits; legal n >= 2; bit counter width = $clog2(n)
// PORTS
//   clk        in   1   single clock; all state updates on posedge
//   reset_n    in   1   asynchronous, active-low reset
//   SI         in   1   serial data bit (driven by upstream SO)
//   SI_valid   in   1   SI is sampled only on cycles where this is high
//   sync       in   1   word-boundary resync; discards any partial word
//   Q          out  n   assembled word (holding register)
//   Q_valid    out  1   Q holds an unconsumed word
//   Q_ready    in   1   consumer accepts Q when Q_valid && Q_ready
//   overrun    out  1   sticky: a completed word was dropped
//   ovr_clr    in   1   synchronous clear of overrun
// BEHAVIOUR
//   Reset (reset_n low, async): shift reg = 0, bit count = 0, Q = 0,
//     Q_valid = 0, overrun = 0. Release takes effect on the next posedge.
//     A reset mid-word discards the partial word; no word is emitted.
//   Shift path, on SI_valid: sh <= {SI, sh[n-1:1]}; cnt <= cnt + 1.
//     The first received bit ends up in Q[0].
//   Word completion: SI_valid && cnt == n-1.
//     - Word w = {SI, sh[n-1:1]}; cnt wraps to 0.
//     - Holding register EMPTY, or FULL and drained this cycle: Q <= w, Q_valid <= 1.
//     - Holding register FULL and not drained: w is dropped, Q is unchanged,
//       overrun <= 1.
//     - Latency: Q_valid rises the cycle after the strobe carrying the last bit.
//   Holding register states:
//     EMPTY -> FULL on word completion.
//     FULL -> EMPTY on Q_valid && Q_ready with no same-cycle completion.
//     FULL -> FULL on a same-cycle completion (back-to-back, no bubble).
//     Q is held stable while Q_valid && !Q_ready.
//     Q_ready while EMPTY has no effect.
//   sync without SI_valid: cnt <= 0; sh is don't-care.
//   sync with SI_valid: the bit is bit 0 of a new word; cnt <= 1.
//     No completion is generated, even if cnt was n-1.
//   sync does not affect Q, Q_valid or overrun.
//   overrun: set on a drop; cleared by ovr_clr.
//     A same-cycle drop and ovr_clr leave overrun = 1 (set wins).
//   No combinational path from any input to any output.
// TESTING (n = 4 unless noted)
//   1. Reset, then SI = 1,0,1,1 on 4 consecutive SI_valid cycles, Q_ready = 1
//      -> next cycle Q = 4'b1101, Q_valid = 1 for exactly 1 cycle.
//   2. Bits 1,0 / SI_valid low 3 cycles / bits 0,1
//      -> Q = 4'b1001; Q_valid rises the cycle after the 4th strobe.
//   3. Q_ready = 0; send words 4'hA then 4'h5
//      -> Q stays 4'hA with Q_valid = 1; overrun = 1 after the 2nd word.
//      Pulse ovr_clr -> overrun = 0, Q still 4'hA.
//   4. Hold Q_ready = 0 until the 4th bit of word 2, then pulse Q_ready with that strobe
//      -> word 1 (4'h3) taken, Q = 4'hC next cycle, Q_valid stays 1, overrun = 0.
//   5. Send 3 bits, sync together with SI_valid (SI = 1), then bits 0,0,1
//      -> single word Q = 4'b1001; no word from the partial.
//   6. Send 2 bits, assert reset_n low mid-cycle
//      -> Q = 0, Q_valid = 0 immediately (async); 4 new bits afterwards yield a clean word.
//      Repeat test 1 with n = 8 -> Q = 8'h5A from bits 0,1,0,1,1,0,1,0.

Source files
------------

// File: rtl/serial_word_collector_if.sv
// Serial-in / word-out bundle between the shift-register source, the collector and its consumer.
interface serial_word_collector_if #(
    parameter int unsigned n = 4
);
    logic         SI;
    logic         SI_valid;
    logic         sync;
    logic [n-1:0] Q;
    logic         Q_valid;
    logic         Q_ready;
    logic         overrun;
    logic         ovr_clr;

    // Collector side: takes the serial stream and control, presents the held word.
    modport slave (
        input  SI,
        input  SI_valid,
        input  sync,
        input  Q_ready,
        input  ovr_clr,
        output Q,
        output Q_valid,
        output overrun
    );

    // Environment side: drives the stream and consumer controls, observes the word.
    modport master (
        output SI,
        output SI_valid,
        output sync,
        output Q_ready,
        output ovr_clr,
        input  Q,
        input  Q_valid,
        input  overrun
    );
endinterface

// File: rtl/serial_word_collector.sv
// Reassembles LSB-first serial bits into n-bit words, parks each word in a
// one-entry holding register drained by valid/ready, and flags dropped words.
module serial_word_collector #(
    parameter int unsigned n = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    serial_word_collector_if.slave   bus
);
    localparam int unsigned CW = (n > 2) ? $clog2(n) : 1;
    localparam int unsigned SW = n - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hold_state_t;

    hold_state_t   state_q, state_d;
    logic [SW-1:0] sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  q_q, q_d;
    logic          ovr_q, ovr_d;

    logic [n-1:0]  word_c;
    logic          complete_c;
    logic          drain_c;

    // Only the upper n-1 bits of the shifter are ever needed: the oldest bit leaves on completion.
    assign word_c     = {bus.SI, sh_q};
    assign complete_c = bus.SI_valid && !bus.sync && (cnt_q == CNT_LAST);
    assign drain_c    = (state_q == ST_FULL) && bus.Q_ready;

    // State, shifter, counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            sh_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state: bit assembly, holding-register occupancy and sticky overrun.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        ovr_d   = ovr_q && !bus.ovr_clr;

        // A sync strobe restarts the word; a bit arriving with it becomes bit 0.
        if (bus.sync) begin
            if (bus.SI_valid) begin
                sh_d  = word_c[n-1:1];
                cnt_d = CNT_ONE;
            end else begin
                cnt_d = '0;
            end
        end else if (bus.SI_valid) begin
            sh_d  = word_c[n-1:1];
            cnt_d = complete_c ? '0 : cnt_q + CNT_ONE;
        end

        unique case (state_q)
            ST_EMPTY: begin
                if (complete_c) begin
                    q_d     = word_c;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (complete_c) begin
                    if (drain_c) begin
                        q_d = word_c;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else if (drain_c) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    assign bus.Q       = q_q;
    assign bus.Q_valid = (state_q == ST_FULL);
    assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_serial_word_collector.sv
// Directed bench for serial_word_collector (n = 4 and n = 8 instances).
module tb_serial_word_collector;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    serial_word_collector_if #(.n(4)) b4 ();
    serial_word_collector_if #(.n(8)) b8 ();

    serial_word_collector #(.n(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b4)
    );

    serial_word_collector #(.n(8)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic b);
        b4.SI       = b;
        b4.SI_valid = 1'b1;
        tick();
        b4.SI_valid = 1'b0;
        b4.SI       = 1'b0;
    endtask

    task automatic send8(input logic b);
        b8.SI       = b;
        b8.SI_valid = 1'b1;
        tick();
        b8.SI_valid = 1'b0;
        b8.SI       = 1'b0;
    endtask

    initial begin
        logic [7:0] v8;
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        b4.SI = 0; b4.SI_valid = 0; b4.sync = 0; b4.Q_ready = 0; b4.ovr_clr = 0;
        b8.SI = 0; b8.SI_valid = 0; b8.sync = 0; b8.Q_ready = 0; b8.ovr_clr = 0;
        #1;
        check("rst_q", 32'(b4.Q), 32'h0);
        check("rst_valid", 32'(b4.Q_valid), 32'h0);
        check("rst_ovr", 32'(b4.overrun), 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Test 1: 1,0,1,1 with Q_ready high -> 4'b1101 valid for one cycle
        b4.Q_ready = 1'b1;
        send4(1'b1); send4(1'b0); send4(1'b1);
        check("t1_valid_pre", 32'(b4.Q_valid), 32'h0);
        send4(1'b1);
        check("t1_q", 32'(b4.Q), 32'hD);
        check("t1_valid", 32'(b4.Q_valid), 32'h1);
        tick();
        check("t1_valid_drop", 32'(b4.Q_valid), 32'h0);

        // Test 2: gaps in SI_valid -> 4'b1001
        send4(1'b1); send4(1'b0);
        tick(); tick(); tick();
        send4(1'b0);
        check("t2_valid_pre", 32'(b4.Q_valid), 32'h0);
        send4(1'b1);
        check("t2_q", 32'(b4.Q), 32'h9);
        check("t2_valid", 32'(b4.Q_valid), 32'h1);
        tick();
        check("t2_valid_drop", 32'(b4.Q_valid), 32'h0);

        // Test 3: stall, drop second word, clear overrun; set wins over clear
        b4.Q_ready = 1'b0;
        send4(1'b0); send4(1'b1); send4(1'b0); send4(1'b1);
        check("t3_q_a", 32'(b4.Q), 32'hA);
        check("t3_ovr_0", 32'(b4.overrun), 32'h0);
        send4(1'b1); send4(1'b0); send4(1'b1); send4(1'b0);
        check("t3_q_hold", 32'(b4.Q), 32'hA);
        check("t3_valid_hold", 32'(b4.Q_valid), 32'h1);
        check("t3_ovr_1", 32'(b4.overrun), 32'h1);
        b4.ovr_clr = 1'b1;
        tick();
        b4.ovr_clr = 1'b0;
        check("t3_ovr_clr", 32'(b4.overrun), 32'h0);
        check("t3_q_after_clr", 32'(b4.Q), 32'hA);
        send4(1'b1); send4(1'b1); send4(1'b1);
        b4.ovr_clr = 1'b1;
        send4(1'b1);
        b4.ovr_clr = 1'b0;
        check("t3_set_wins", 32'(b4.overrun), 32'h1);
        check("t3_q_still_a", 32'(b4.Q), 32'hA);
        b4.ovr_clr = 1'b1;
        tick();
        b4.ovr_clr = 1'b0;
        b4.Q_ready = 1'b1;
        tick();
        b4.Q_ready = 1'b0;
        check("t3_drained", 32'(b4.Q_valid), 32'h0);
        check("t3_ovr_clr2", 32'(b4.overrun), 32'h0);

        // Test 4: drain on the completing strobe -> back-to-back, no overrun
        send4(1'b1); send4(1'b1); send4(1'b0); send4(1'b0);
        check("t4_q_3", 32'(b4.Q), 32'h3);
        tick();
        check("t4_q_stable", 32'(b4.Q), 32'h3);
        send4(1'b0); send4(1'b0); send4(1'b1);
        b4.Q_ready = 1'b1;
        send4(1'b1);
        b4.Q_ready = 1'b0;
        check("t4_q_c", 32'(b4.Q), 32'hC);
        check("t4_valid", 32'(b4.Q_valid), 32'h1);
        check("t4_ovr", 32'(b4.overrun), 32'h0);
        b4.Q_ready = 1'b1;
        tick();
        check("t4_drained", 32'(b4.Q_valid), 32'h0);
        tick();
        check("t4_ready_empty", 32'(b4.Q_valid), 32'h0);
        b4.Q_ready = 1'b0;

        // Test 5: sync with SI_valid restarts the word
        send4(1'b1); send4(1'b1); send4(1'b1);
        b4.sync = 1'b1;
        send4(1'b1);
        b4.sync = 1'b0;
        check("t5_no_partial", 32'(b4.Q_valid), 32'h0);
        send4(1'b0); send4(1'b0);
        check("t5_valid_pre", 32'(b4.Q_valid), 32'h0);
        send4(1'b1);
        check("t5_q", 32'(b4.Q), 32'h9);
        check("t5_valid", 32'(b4.Q_valid), 32'h1);
        b4.Q_ready = 1'b1;
        tick();
        b4.Q_ready = 1'b0;
        // sync alone zeroes the bit count
        send4(1'b1); send4(1'b1);
        b4.sync = 1'b1;
        tick();
        b4.sync = 1'b0;
        send4(1'b0); send4(1'b1); send4(1'b1);
        check("t5b_valid_pre", 32'(b4.Q_valid), 32'h0);
        send4(1'b0);
        check("t5b_q", 32'(b4.Q), 32'h6);

        // Test 6: async reset mid-word clears everything immediately
        send4(1'b1); send4(1'b1); send4(1'b1); send4(1'b1);
        check("t6_ovr_pre", 32'(b4.overrun), 32'h1);
        send4(1'b1); send4(1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_q", 32'(b4.Q), 32'h0);
        check("t6_rst_valid", 32'(b4.Q_valid), 32'h0);
        check("t6_rst_ovr", 32'(b4.overrun), 32'h0);
        #3;
        reset_n = 1'b1;
        tick();
        send4(1'b1); send4(1'b0); send4(1'b1);
        check("t6_valid_pre", 32'(b4.Q_valid), 32'h0);
        send4(1'b0);
        check("t6_q", 32'(b4.Q), 32'h5);
        check("t6_valid", 32'(b4.Q_valid), 32'h1);

        // n = 8: bits 0,1,0,1,1,0,1,0 -> 8'h5A
        b8.Q_ready = 1'b1;
        v8 = 8'b0101_1010;
        for (int i = 0; i < 7; i++) send8(v8[i]);
        check("n8_valid_pre", 32'(b8.Q_valid), 32'h0);
        send8(v8[7]);
        check("n8_q", 32'(b8.Q), 32'h5A);
        check("n8_valid", 32'(b8.Q_valid), 32'h1);
        tick();
        check("n8_valid_drop", 32'(b8.Q_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
